// File: rtl/rr_mux_arb.sv
// rr_mux_arb: N-channel valid/ready mux with fixed-select or round-robin grant and a registered output
module rr_mux_arb #(
    parameter int N_CH = 4,
    parameter int W    = 8,
    parameter int CW   = $clog2(N_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mode,
    input  logic [CW-1:0]     sel,
    input  logic [N_CH*W-1:0] in_data,
    input  logic [N_CH-1:0]   in_valid,
    output logic [N_CH-1:0]   in_ready,
    output logic [W-1:0]      out_data,
    output logic [CW-1:0]     out_ch,
    output logic              out_valid,
    input  logic              out_ready
);
    localparam int NP = 1 << CW;
    logic [NP-1:0] vpad;
    logic [CW-1:0] rr_ptr, gidx;
    logic          hit, go, can_load;
    assign can_load = !out_valid || out_ready;
    // zero-padded valids make an out-of-range sel read as "not requesting"
    always_comb begin
        vpad = '0;
        vpad[N_CH-1:0] = in_valid;
        hit = 1'b0;
        gidx = sel;
        if (mode) begin
            for (int i = 0; i < N_CH; i++) begin
                if (!hit && in_valid[(int'(rr_ptr) + i) % N_CH]) begin
                    hit = 1'b1;
                    gidx = CW'((int'(rr_ptr) + i) % N_CH);
                end
            end
        end else begin
            hit = vpad[sel];
        end
    end
    assign go = hit && can_load && rst_n;
    assign in_ready = go ? N_CH'(1) << gidx : '0;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            rr_ptr    <= '0;
        end else if (go) begin
            out_valid <= 1'b1;
            out_data  <= in_data[gidx*W +: W];
            out_ch    <= gidx;
            if (mode) rr_ptr <= (gidx == CW'(N_CH - 1)) ? '0 : gidx + 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_rr_mux_arb.sv
// tb_rr_mux_arb: directed stimulus with a queue scoreboard checked by an independent output monitor
module tb_rr_mux_arb;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, mode, out_ready, out_valid;
    logic [1:0] sel, out_ch;
    logic [31:0] in_data;
    logic [3:0] in_valid, in_ready;
    logic [7:0] out_data;

    logic mode3, out_ready3, out_valid3;
    logic [1:0] sel3, out_ch3;
    logic [23:0] in_data3;
    logic [2:0] in_valid3, in_ready3;
    logic [7:0] out_data3;

    int vecs = 0, errs = 0;
    logic [9:0] sb[$];

    rr_mux_arb #(.N_CH(4), .W(8)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
        .out_ch(out_ch), .out_valid(out_valid), .out_ready(out_ready)
    );

    rr_mux_arb #(.N_CH(3), .W(8)) dut3 (
        .clk(clk), .rst_n(rst_n), .mode(mode3), .sel(sel3), .in_data(in_data3),
        .in_valid(in_valid3), .in_ready(in_ready3), .out_data(out_data3),
        .out_ch(out_ch3), .out_valid(out_valid3), .out_ready(out_ready3)
    );

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        vecs++;
        if (a !== e) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
        end
    endtask

    // one cycle: check grant at negedge, queue the words it should produce, then advance
    task automatic cyc(input logic [3:0] er);
        @(negedge clk);
        chk("in_ready", {28'd0, in_ready}, {28'd0, er});
        for (int k = 0; k < 4; k++)
            if (er[k]) sb.push_back({2'(k), in_data[k*8 +: 8]});
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [9:0] e;
        forever begin
            @(negedge clk);
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                if (sb.size() == 0) begin
                    vecs++;
                    errs++;
                    $display("FAIL unexpected_word: got ch=%0d data=%h expected none", out_ch, out_data);
                end else begin
                    e = sb.pop_front();
                    chk("out_word", {22'd0, out_ch, out_data}, {22'd0, e});
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 0; mode = 0; sel = 0; out_ready = 1; in_valid = 4'b1111;
        in_data = {8'h13, 8'h12, 8'h11, 8'h10};
        mode3 = 0; sel3 = 0; out_ready3 = 1; in_valid3 = 0; in_data3 = {8'h22, 8'h21, 8'h20};
        cyc(4'b0000);
        cyc(4'b0000);
        chk("rst_out_valid", {31'd0, out_valid}, 0);
        chk("rst_out_data", {24'd0, out_data}, 0);
        chk("rst_out_ch", {30'd0, out_ch}, 0);

        rst_n = 1; in_valid = 0;
        cyc(4'b0000);
        cyc(4'b0000);
        chk("idle_out_valid", {31'd0, out_valid}, 0);

        sel = 2; in_valid = 4'b1111;
        repeat (4) cyc(4'b0100);
        in_valid = 0;
        cyc(4'b0000);

        mode = 1; in_valid = 4'b1111;
        cyc(4'b0001); cyc(4'b0010); cyc(4'b0100); cyc(4'b1000); cyc(4'b0001); cyc(4'b0010);
        cyc(4'b0100); cyc(4'b1000);
        in_valid = 4'b1010;
        cyc(4'b0010); cyc(4'b1000); cyc(4'b0010); cyc(4'b1000);
        in_valid = 4'b1111;
        cyc(4'b0001);

        mode = 0; sel = 1; in_valid = 4'b0010; in_data[15:8] = 8'hAB;
        cyc(4'b0010);
        out_ready = 0; in_data[15:8] = 8'h5C;
        repeat (3) begin
            cyc(4'b0000);
            chk("stall_data", {24'd0, out_data}, 32'hAB);
            chk("stall_valid", {31'd0, out_valid}, 1);
        end
        out_ready = 1;
        cyc(4'b0010);
        in_valid = 0;
        cyc(4'b0000);

        in_valid = 4'b0010; in_data[15:8] = 8'h77;
        cyc(4'b0010);
        out_ready = 0; in_valid = 0;
        cyc(4'b0000);
        chk("full_before_rst", {31'd0, out_valid}, 1);
        rst_n = 0;
        cyc(4'b0000);
        chk("rst_mid_stall", {31'd0, out_valid}, 0);
        sb.delete();
        rst_n = 1; out_ready = 1; mode = 1; in_valid = 4'b1111;
        cyc(4'b0001);
        in_valid = 0;
        cyc(4'b0000);

        sel3 = 2'd3; in_valid3 = 3'b111;
        repeat (2) begin
            @(negedge clk);
            chk("oor_in_ready", {29'd0, in_ready3}, 0);
            chk("oor_out_valid", {31'd0, out_valid3}, 0);
            @(posedge clk); #1;
        end
        sel3 = 2'd2;
        @(negedge clk);
        chk("sel2_in_ready", {29'd0, in_ready3}, 32'h4);
        @(posedge clk); #1;
        chk("sel2_word", {22'd0, out_ch3, out_data3}, {22'd0, 2'd2, 8'h22});

        @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
